// File: rtl/osc_pkg.sv
// Shared types and sizing helpers for the wavetable oscillator.
package osc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StCapture,
        StOut
    } osc_state_e;

    // Mix accumulator width that can hold num_voices full-scale samples without overflow.
    function automatic int acc_width(input int num_voices, input int sample_w);
        return sample_w + $clog2(num_voices);
    endfunction

endpackage

// File: rtl/osc_pulse_det.sv
// Two-flop synchroniser plus rising-edge detector for one asynchronous button bit.
module osc_pulse_det (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    // [0],[1] synchronise; [2] remembers the previous synchronised level.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], btn_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/wavetable_osc.sv
// Time-multiplexed wavetable oscillator: one shared LUT port, 2 cycles per voice, mixed output.
// Define SUM_SAT_EN to saturate the voice sum; otherwise the sum is averaged.
module wavetable_osc
    import osc_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned PHASE_W    = 16,
    parameter int unsigned LUT_AW     = 12,
    parameter int unsigned SAMPLE_W   = 8,
    parameter int unsigned MAX_OCT    = 7
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sample_tick,
    input  logic [NUM_VOICES-1:0]            voice_en,
    input  logic [NUM_VOICES*PHASE_W-1:0]    base_step,
    input  logic [NUM_VOICES-1:0]            oct_up,
    input  logic [NUM_VOICES-1:0]            oct_down,
    output logic                             lut_rd,
    output logic [LUT_AW-1:0]                lut_addr,
    input  logic signed [SAMPLE_W-1:0]       lut_data,
    output logic                             agg_valid,
    output logic signed [SAMPLE_W-1:0]       agg_data,
    input  logic                             agg_ack,
    output logic                             busy,
    output logic                             overrun
);

    localparam int ACC_W = acc_width(NUM_VOICES, SAMPLE_W);
    localparam int SH    = ACC_W - SAMPLE_W;
    localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int OCT_W = (MAX_OCT > 0) ? $clog2(MAX_OCT + 1) : 1;

    localparam logic [OCT_W-1:0]        OCT_MAX = OCT_W'(MAX_OCT);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(SH + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(SH + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};

    osc_state_e                 state_q;
    logic [VW-1:0]              voice_q, voice_nxt;
    logic [PHASE_W-1:0]         phase_q [NUM_VOICES];
    logic [OCT_W-1:0]           oct_q   [NUM_VOICES];
    logic signed [ACC_W-1:0]    acc_q;
    logic [PHASE_W-1:0]         step;
    logic signed [SAMPLE_W-1:0] result;
    logic [NUM_VOICES-1:0]      up_rise, dn_rise;
    logic                       lut_rd_q, agg_valid_q, busy_q, overrun_q;
    logic [LUT_AW-1:0]          lut_addr_q;
    logic signed [SAMPLE_W-1:0] agg_data_q;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_btn
        osc_pulse_det u_up (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (oct_up[v]),
            .rise_o (up_rise[v])
        );
        osc_pulse_det u_dn (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (oct_down[v]),
            .rise_o (dn_rise[v])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) oct_q[v] <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (up_rise[v] && !dn_rise[v]) begin
                    if (oct_q[v] != OCT_MAX) oct_q[v] <= oct_q[v] + 1'b1;
                end else if (dn_rise[v] && !up_rise[v]) begin
                    if (oct_q[v] != '0) oct_q[v] <= oct_q[v] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        voice_nxt = voice_q + 1'b1;
        step      = base_step[voice_q*PHASE_W +: PHASE_W] << oct_q[voice_q];
    end

`ifdef SUM_SAT_EN
    always_comb begin
        if (acc_q > ACC_MAX) begin
            result = ACC_MAX[SAMPLE_W-1:0];
        end else if (acc_q < ACC_MIN) begin
            result = ACC_MIN[SAMPLE_W-1:0];
        end else begin
            result = acc_q[SAMPLE_W-1:0];
        end
    end
`else
    logic signed [ACC_W-1:0] acc_shr;
    always_comb begin
        acc_shr = acc_q >>> SH;
        result  = acc_shr[SAMPLE_W-1:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            voice_q     <= '0;
            acc_q       <= '0;
            lut_rd_q    <= 1'b0;
            lut_addr_q  <= '0;
            agg_valid_q <= 1'b0;
            agg_data_q  <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) phase_q[v] <= '0;
        end else begin
            overrun_q <= sample_tick && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (sample_tick) begin
                        state_q    <= StFetch;
                        busy_q     <= 1'b1;
                        voice_q    <= '0;
                        lut_rd_q   <= voice_en[0];
                        lut_addr_q <= phase_q[0][PHASE_W-1 -: LUT_AW];
                    end
                end
                StFetch: begin
                    state_q  <= StCapture;
                    lut_rd_q <= 1'b0;
                end
                StCapture: begin
                    if (voice_en[voice_q]) begin
                        acc_q            <= acc_q + ACC_W'(lut_data);
                        phase_q[voice_q] <= phase_q[voice_q] + step;
                    end else begin
                        phase_q[voice_q] <= '0;
                    end
                    if (voice_q == VW'(NUM_VOICES - 1)) begin
                        state_q <= StOut;
                    end else begin
                        state_q    <= StFetch;
                        voice_q    <= voice_nxt;
                        lut_rd_q   <= voice_en[voice_nxt];
                        lut_addr_q <= phase_q[voice_nxt][PHASE_W-1 -: LUT_AW];
                    end
                end
                StOut: begin
                    // First OUT cycle registers the mix; handshake only counts once valid is up.
                    if (!agg_valid_q) begin
                        agg_valid_q <= 1'b1;
                        agg_data_q  <= result;
                    end else if (agg_ack) begin
                        agg_valid_q <= 1'b0;
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        acc_q       <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign lut_rd    = lut_rd_q;
    assign lut_addr  = lut_addr_q;
    assign agg_valid = agg_valid_q;
    assign agg_data  = agg_data_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/wavetable_osc.md
WAVETABLE_OSC -- requirements
Module: wavetable_osc

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of time-multiplexed voices (1..16).
REQ-002 SHALL have parameter PHASE_W, default 16, phase-accumulator width per voice.
REQ-003 SHALL have parameter LUT_AW, default 12, LUT address width (<= PHASE_W).
REQ-004 SHALL have parameter SAMPLE_W, default 8, signed sample width.
REQ-005 SHALL have parameter MAX_OCT, default 7, highest octave shift.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 sample_tick  in  1  one-cycle pulse starting a mix frame.
REQ-009 voice_en  in  NUM_VOICES  per-voice enable.
REQ-010 base_step  in  NUM_VOICES*PHASE_W  per-voice phase increment, voice v at bits [v*PHASE_W +: PHASE_W].
REQ-011 oct_up / oct_down  in  NUM_VOICES each  asynchronous per-voice octave buttons, level.
REQ-012 lut_rd  out  1  LUT read strobe; lut_addr  out  LUT_AW  read address.
REQ-013 lut_data  in  SAMPLE_W  signed LUT sample, valid exactly one cycle after lut_rd.
REQ-014 agg_valid  out  1; agg_data  out  SAMPLE_W signed; agg_ack  in  1  aggregator handshake.
REQ-015 busy  out  1  high whenever FSM not IDLE; overrun  out  1  one-cycle pulse on dropped tick.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, CAPTURE, OUT; IDLE->FETCH(voice 0) on sample_tick.
REQ-017 FETCH(v): enabled voice -> lut_rd=1, lut_addr=phase[v][PHASE_W-1 -: LUT_AW]; disabled -> lut_rd=0.
REQ-018 CAPTURE(v): enabled voice -> accumulator += sign-extended lut_data, phase[v] += step[v] mod 2^PHASE_W; disabled -> adds 0, phase[v] cleared to 0.
REQ-019 CAPTURE(v) -> FETCH(v+1), or OUT after voice NUM_VOICES-1; every voice costs exactly 2 cycles regardless of enable.
REQ-020 agg_valid SHALL rise exactly 2*NUM_VOICES+1 cycles after the edge sampling sample_tick, agg_data stable while high.
REQ-021 agg_valid held until agg_ack sampled high; next cycle agg_valid=0, FSM IDLE, accumulator cleared; agg_ack outside OUT ignored.
REQ-022 sample_tick while busy SHALL be dropped and pulse overrun for one cycle; frame in progress unaffected.
REQ-023 step[v] = (base_step[v] << oct[v]) truncated to PHASE_W bits, sampled at CAPTURE(v).
REQ-024 oct[v] range 0..MAX_OCT, reset 0; synchronised rising edge of oct_up increments, oct_down decrements, saturating at bounds.
REQ-025 Simultaneous up and down edges on the same voice SHALL leave oct[v] unchanged; octave updates act in every FSM state.
REQ-026 Accumulator width SHALL be SAMPLE_W+clog2(NUM_VOICES) to never overflow.

Reset
REQ-027 rst_n low SHALL immediately force: FSM IDLE, all phase and oct registers 0, accumulator 0, lut_rd/agg_valid/overrun/busy 0, lut_addr 0, agg_data 0, synchroniser flops 0.
REQ-028 Reset mid-frame SHALL abandon the frame; no agg_valid is produced for it after release.

Configuration
REQ-029 With SUM_SAT_EN defined, agg_data SHALL be the accumulator saturated to signed SAMPLE_W range.
REQ-030 Without SUM_SAT_EN, agg_data SHALL be the accumulator arithmetically shifted right by clog2(NUM_VOICES) (average).

Structure
REQ-031 Shared package osc_pkg SHALL hold the FSM state enum and the clog2-derived accumulator-width constant function.
REQ-032 Sub-module osc_pulse_det SHALL provide 2-flop synchronisation plus rising-edge detection for one button bit; instantiated 2*NUM_VOICES times.

Verification
REQ-033 Reset, NUM_VOICES=4, all enabled, base_step=0x0100, LUT returns 10 -> agg_valid at cycle 9 after tick, agg_data=40 (SAT) or 10 (avg); phases 0x0100.
REQ-034 Voice 1 disabled, others as REQ-033 -> no lut_rd in voice 1 FETCH, phase[1]=0, agg_data=30 (SAT) or 7 (avg).
REQ-035 LUT returns 127 all voices, SUM_SAT_EN -> agg_data=127; without -> 127.
REQ-036 Eight oct_up edges on voice 0 -> oct=7, step=0x0100<<7=0x8000; phase wraps 0x8000->0x0000 on second frame.
REQ-037 sample_tick during OUT with agg_ack withheld 5 cycles -> overrun one-cycle pulse, agg_data unchanged, single frame delivered after ack.
REQ-038 rst_n low in CAPTURE of voice 2 -> all outputs 0 asynchronously, no agg_valid until a new tick.
